multicycle_control: RTL and testbench

Multi-cycle MIPS main control FSM that sequences a shared-ALU, single-memory datapath across FETCH/DECODE/EXECUTE/MEM/WB steps. It supports R-type, lw, sw, beq, j and addi. It stalls on a memory ready handshake, and it flags illegal opcodes and instruction completion. The block sits beside the ALU control decoder, which consumes ALUOp.

---
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for a multi-cycle MIPS datapath with a shared ALU and a single memory.
// The next state is registered; the control outputs are decoded combinationally from the current state.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE | register read, branch target into ALUOut
// MEMADR | effective address = A + sign-extended imm
// MEMRD  | load data read (waits on mem_ready)
// MEMWB  | load data written to rt
// MEMWR  | store write (waits on mem_ready)
// EXEC   | R-type ALU operation
// ALUWB  | R-type result written to rd
// BRANCH | beq compare, conditional PC load
// JUMP   | PC <= jump target
// ADDIEX | addi ALU operation
// ADDIWB | addi result written to rt
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       regDest,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t st;
  logic   rdy;

  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= FETCH;
    end else begin
      case (st)
        FETCH:  st <= rdy ? DECODE : FETCH;
        DECODE: begin
          case (opcode)
            OP_RTYPE:      st <= EXEC;
            OP_LW, OP_SW:  st <= MEMADR;
            OP_BEQ:        st <= BRANCH;
            OP_J:          st <= JUMP;
            OP_ADDI:       st <= ADDIEX;
            default:       st <= FETCH;
          endcase
        end
        MEMADR: st <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  st <= rdy ? MEMWB : MEMRD;
        MEMWB:  st <= FETCH;
        MEMWR:  st <= rdy ? FETCH : MEMWR;
        EXEC:   st <= ALUWB;
        ALUWB:  st <= FETCH;
        BRANCH: st <= FETCH;
        JUMP:   st <= FETCH;
        ADDIEX: st <= ADDIWB;
        ADDIWB: st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dest, reg_write, alu_src_a, done, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       op_known;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_known = 1'b1;
      default:                                       op_known = 1'b0;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dest      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    done          = 1'b0;
    illegal       = 1'b0;
    case (st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        illegal   = ~op_known;
        done      = ~op_known;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = rdy;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
        done      = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        done          = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        done      = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks everything so no write or memory request escapes while it is held.
  assign PCWrite     = ~reset & pc_write;
  assign PCWriteCond = ~reset & pc_write_cond;
  assign IorD        = ~reset & iord;
  assign MemRead     = ~reset & mem_read;
  assign MemWrite    = ~reset & mem_write;
  assign IRWrite     = ~reset & ir_write;
  assign MemtoReg    = ~reset & mem_to_reg;
  assign regDest     = ~reset & reg_dest;
  assign RegWrite    = ~reset & reg_write;
  assign ALUSrcA     = ~reset & alu_src_a;
  assign ALUSrcB     = reset ? 2'b00 : alu_src_b;
  assign ALUOp       = reset ? 2'b00 : alu_op;
  assign PCSource    = reset ? 2'b00 : pc_source;
  assign instr_done  = ~reset & done;
  assign illegal_op  = ~reset & illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model predicts every output each cycle,
// and literal pulse counts pin the model on the key scenarios.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, regDest, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .regDest(regDest),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,regDest,RegWrite,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSource,instr_done,illegal_op,state}
  logic [21:0] act, exp_v;
  bit          exp_valid = 1'b0;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, regDest,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, state};

  int checks = 0, errors = 0;
  int n_done = 0, n_ill = 0, n_rw = 0, n_mw = 0, n_mr = 0, n_ir = 0, n_pcw = 0, n_mtr = 0;

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h (state actual=%0d required=%0d)",
                 $time, act, exp_v, act[3:0], exp_v[3:0]);
      end
      n_done += int'(instr_done);
      n_ill  += int'(illegal_op);
      n_rw   += int'(RegWrite);
      n_mw   += int'(MemWrite);
      n_mr   += int'(MemRead);
      n_ir   += int'(IRWrite);
      n_pcw  += int'(PCWrite);
      n_mtr  += int'(MemtoReg);
    end
  end

  task automatic check_lit(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  // Expected outputs for one step of an instruction's walk through the datapath.
  function automatic logic [21:0] model(input int s, input bit rdy, input bit ill);
    logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, mtr = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sb = 2'b00, aop = 2'b00, pcs = 2'b00;
    logic done = 0, illg = 0;
    case (s)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; illg = ill; done = ill; end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; mtr = 1; done = 1; end
      5:  begin mw = 1; iord = 1; done = rdy; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, mtr, rd, rw, sa, sb, aop, pcs, done, illg, 4'(s)};
  endfunction

  task automatic step(input int s, input bit r, input bit ill);
    mem_ready = r;
    exp_v     = model(s, r, ill);
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction; fstall/mstall = cycles mem_ready is held low in FETCH / memory access.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
    int  seq[$];
    bit  ill;
    case (op)
      6'b100011: seq = {0, 1, 2, 3, 4};
      6'b101011: seq = {0, 1, 2, 5};
      6'b000000: seq = {0, 1, 6, 7};
      6'b001000: seq = {0, 1, 10, 11};
      6'b000100: seq = {0, 1, 8};
      6'b000010: seq = {0, 1, 9};
      default:   seq = {0, 1};
    endcase
    opcode = op;
    ill    = !is_legal(op);
    foreach (seq[i]) begin
      int s = seq[i];
      int stall = (s == 0) ? fstall : ((s == 3 || s == 5) ? mstall : 0);
      bit waits = (s == 0 || s == 3 || s == 5);
      for (int w = 0; w <= stall; w++) begin
        // Outside wait states mem_ready toggles to show it is ignored there.
        step(s, waits ? (w == stall) : bit'(i % 2), (s == 1) && ill);
      end
    end
  endtask

  int b_done, b_ill, b_rw, b_mw, b_mr, b_ir, b_pcw, b_mtr;
  task automatic snap();
    b_done = n_done; b_ill = n_ill; b_rw = n_rw; b_mw = n_mw;
    b_mr = n_mr; b_ir = n_ir; b_pcw = n_pcw; b_mtr = n_mtr;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
    exp_v = 22'h0; exp_valid = 1'b1;
    @(posedge clk); #1;
    check_lit("reset_memread", int'(MemRead), 0);
    check_lit("reset_state", int'(state), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    snap(); run_instr(6'b100011, 0, 0);
    check_lit("lw_done", n_done - b_done, 1);
    check_lit("lw_irwrite", n_ir - b_ir, 1);
    check_lit("lw_pcwrite", n_pcw - b_pcw, 1);
    check_lit("lw_regwrite", n_rw - b_rw, 1);
    check_lit("lw_memtoreg", n_mtr - b_mtr, 1);

    snap(); run_instr(6'b000000, 0, 0);
    check_lit("rtype_done", n_done - b_done, 1);
    check_lit("rtype_regwrite", n_rw - b_rw, 1);

    snap(); run_instr(6'b101011, 0, 2);
    check_lit("sw_memwrite_cycles", n_mw - b_mw, 3);
    check_lit("sw_done", n_done - b_done, 1);
    check_lit("sw_regwrite", n_rw - b_rw, 0);

    snap(); run_instr(6'b000000, 3, 0);
    check_lit("fetch_stall_memread", n_mr - b_mr, 4);
    check_lit("fetch_stall_irwrite", n_ir - b_ir, 1);
    check_lit("fetch_stall_pcwrite", n_pcw - b_pcw, 1);

    snap();
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    check_lit("br_j_ill_done", n_done - b_done, 3);
    check_lit("illegal_pulses", n_ill - b_ill, 1);
    check_lit("br_j_ill_pcwrite", n_pcw - b_pcw, 4);

    run_instr(6'b001000, 1, 0);
    snap(); run_instr(6'b100011, 2, 3);
    check_lit("lw_stall_memread", n_mr - b_mr, 7);
    check_lit("lw_stall_regwrite", n_rw - b_rw, 1);
    run_instr(6'b101011, 0, 0);

    // Asynchronous reset while a store is stalled in MEMWR.
    snap();
    opcode = 6'b101011;
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    mem_ready = 1'b0;
    exp_v = model(5, 1'b0, 1'b0);
    exp_valid = 1'b0;
    check_lit("pre_reset_memwrite", int'(MemWrite), 1);
    #2 reset = 1'b1;
    #1;
    check_lit("async_reset_memwrite", int'(MemWrite), 0);
    check_lit("async_reset_state", int'(state), 0);
    exp_v = 22'h0; exp_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_lit("reset_window_done", n_done - b_done, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 1);

    exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
